// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit: states,
// opcode/funct values, ALU operation codes and datapath select codes.
package multicycle_pkg;

  localparam logic [3:0] ST_FETCH     = 4'd0;
  localparam logic [3:0] ST_DECODE    = 4'd1;
  localparam logic [3:0] ST_EXEC_R    = 4'd2;
  localparam logic [3:0] ST_R_WB      = 4'd3;
  localparam logic [3:0] ST_EXEC_I    = 4'd4;
  localparam logic [3:0] ST_I_WB      = 4'd5;
  localparam logic [3:0] ST_MEM_ADDR  = 4'd6;
  localparam logic [3:0] ST_MEM_READ  = 4'd7;
  localparam logic [3:0] ST_MEM_WB    = 4'd8;
  localparam logic [3:0] ST_MEM_WRITE = 4'd9;
  localparam logic [3:0] ST_BRANCH    = 4'd10;
  localparam logic [3:0] ST_JUMP      = 4'd11;

  typedef enum logic [3:0] {
    S_FETCH     = ST_FETCH,
    S_DECODE    = ST_DECODE,
    S_EXEC_R    = ST_EXEC_R,
    S_R_WB      = ST_R_WB,
    S_EXEC_I    = ST_EXEC_I,
    S_I_WB      = ST_I_WB,
    S_MEM_ADDR  = ST_MEM_ADDR,
    S_MEM_READ  = ST_MEM_READ,
    S_MEM_WB    = ST_MEM_WB,
    S_MEM_WRITE = ST_MEM_WRITE,
    S_BRANCH    = ST_BRANCH,
    S_JUMP      = ST_JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_NOR = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SHL = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Which rule the ALU decoder applies in the current state.
  typedef enum logic [2:0] {
    ALU_CLS_NONE,
    ALU_CLS_ADD,
    ALU_CLS_SUB,
    ALU_CLS_FUNCT,
    ALU_CLS_IMM
  } alu_class_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Datapath-facing signal bundle of the control unit. master = control unit,
// slave = datapath. state is a debug view of the FSM register.
interface multicycle_control_unit_if;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;
  logic       PCEnable;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ExtOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic [3:0] ALUOperation;
  logic       IllegalInstr;
  logic [3:0] state;

  modport master (
    input  Opcode, Funct, Zero, MemReady,
    output PCEnable, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
           RegWrite, ExtOp, ALUSrcA, ALUSrcB, PCSource, ALUOperation,
           IllegalInstr, state
  );

  modport slave (
    output Opcode, Funct, Zero, MemReady,
    input  PCEnable, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
           RegWrite, ExtOp, ALUSrcA, ALUSrcB, PCSource, ALUOperation,
           IllegalInstr, state
  );
endinterface

// File: rtl/multicycle_control_unit_alu_op_decoder.sv
// Combinational ALU operation select from the state class, opcode and funct;
// also flags whether funct is one of the supported R-type operations.
module alu_op_decoder
  import multicycle_pkg::*;
(
  input  alu_class_t alu_class,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       funct_legal
);

  logic [3:0] rtype_op;

  always_comb begin
    funct_legal = 1'b1;
    rtype_op    = ALU_AND;
    case (funct)
      FN_ADD:  rtype_op = ALU_ADD;
      FN_SUB:  rtype_op = ALU_SUB;
      FN_AND:  rtype_op = ALU_AND;
      FN_OR:   rtype_op = ALU_OR;
      FN_NOR:  rtype_op = ALU_NOR;
      default: funct_legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_op = ALU_AND;
    case (alu_class)
      ALU_CLS_ADD:   alu_op = ALU_ADD;
      ALU_CLS_SUB:   alu_op = ALU_SUB;
      ALU_CLS_FUNCT: alu_op = rtype_op;
      ALU_CLS_IMM:   alu_op = (opcode == OP_ORI) ? ALU_OR : ALU_ADD;
      default:       alu_op = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-subset control FSM: fetch/decode/execute/memory/writeback
// sequencing, ALU operation and operand selects, memory-ready stalls.
module multicycle_control_unit
  import multicycle_pkg::*;
#(
  parameter logic [1:0] PC_INCREMENT_SEL = SRCB_FOUR
) (
  input logic                        clk,
  input logic                        reset,
  multicycle_control_unit_if.master  bus
);

  state_t     state, state_next;
  alu_class_t alu_class;
  logic [3:0] alu_op;
  logic       funct_legal;
  // Opcode-derived choices captured while the IR is known stable.
  logic       is_store_q, is_ori_q;

  logic pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_dst, reg_write, ext_op, alu_src_a, illegal;
  logic [1:0] alu_src_b, pc_source;

  alu_op_decoder u_alu_op_decoder (
    .alu_class   (alu_class),
    .opcode      (bus.Opcode),
    .funct       (bus.Funct),
    .alu_op      (alu_op),
    .funct_legal (funct_legal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_FETCH;
      is_store_q <= 1'b0;
      is_ori_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_DECODE) is_store_q <= (bus.Opcode == OP_SW);
      if (state == S_EXEC_I) is_ori_q   <= (bus.Opcode == OP_ORI);
    end
  end

  always_comb begin
    state_next    = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    ext_op        = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    pc_source     = PCSRC_ALU;
    alu_class     = ALU_CLS_NONE;
    illegal       = 1'b0;
    // Reset overrides the state decode so no enable leaks out mid-instruction.
    if (reset) begin
      alu_src_b = PC_INCREMENT_SEL;
      alu_class = ALU_CLS_ADD;
    end else begin
      case (state)
        S_FETCH: begin
          mem_read   = 1'b1;
          alu_src_b  = PC_INCREMENT_SEL;
          alu_class  = ALU_CLS_ADD;
          ir_write   = bus.MemReady;
          pc_write   = bus.MemReady;
          state_next = bus.MemReady ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMM_SHL;
          alu_class = ALU_CLS_ADD;
          case (bus.Opcode)
            OP_RTYPE: begin
              if (funct_legal) state_next = S_EXEC_R;
              else             illegal    = 1'b1;
            end
            OP_LW, OP_SW:    state_next = S_MEM_ADDR;
            OP_BEQ:          state_next = S_BRANCH;
            OP_ADDI, OP_ORI: state_next = S_EXEC_I;
            OP_J:            state_next = S_JUMP;
            default:         illegal    = 1'b1;
          endcase
        end
        S_EXEC_R: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_B;
          alu_class  = ALU_CLS_FUNCT;
          state_next = S_R_WB;
        end
        S_R_WB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
        end
        S_EXEC_I: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_IMM;
          ext_op     = (bus.Opcode == OP_ORI);
          alu_class  = ALU_CLS_IMM;
          state_next = S_I_WB;
        end
        S_I_WB: begin
          reg_write = 1'b1;
          ext_op    = is_ori_q;
        end
        S_MEM_ADDR: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_IMM;
          alu_class  = ALU_CLS_ADD;
          state_next = is_store_q ? S_MEM_WRITE : S_MEM_READ;
        end
        S_MEM_READ: begin
          iord       = 1'b1;
          mem_read   = 1'b1;
          state_next = bus.MemReady ? S_MEM_WB : S_MEM_READ;
        end
        S_MEM_WB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
        end
        S_MEM_WRITE: begin
          iord       = 1'b1;
          mem_write  = 1'b1;
          state_next = bus.MemReady ? S_FETCH : S_MEM_WRITE;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_src_b     = SRCB_B;
          alu_class     = ALU_CLS_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = PCSRC_JUMP;
        end
        default: state_next = S_FETCH;
      endcase
    end
  end

  assign bus.PCEnable     = pc_write | (pc_write_cond & bus.Zero);
  assign bus.IorD         = iord;
  assign bus.MemRead      = mem_read;
  assign bus.MemWrite     = mem_write;
  assign bus.IRWrite      = ir_write;
  assign bus.MemtoReg     = mem_to_reg;
  assign bus.RegDst       = reg_dst;
  assign bus.RegWrite     = reg_write;
  assign bus.ExtOp        = ext_op;
  assign bus.ALUSrcA      = alu_src_a;
  assign bus.ALUSrcB      = alu_src_b;
  assign bus.PCSource     = pc_source;
  assign bus.ALUOperation = alu_op;
  assign bus.IllegalInstr = illegal;
  assign bus.state        = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: each driven cycle pushes its
// hand-computed output vector; a negedge monitor pops and compares.
module tb_multicycle_control_unit;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, R_WB = 4'd3,
                         EXEC_I = 4'd4, I_WB = 4'd5, MEM_ADDR = 4'd6, MEM_READ = 4'd7,
                         MEM_WB = 4'd8, MEM_WRITE = 4'd9, BRANCH = 4'd10, JUMP = 4'd11;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       ext_op;
    logic       src_a;
    logic [1:0] src_b;
    logic [1:0] pc_src;
    logic [3:0] alu;
    logic       ill;
  } outs_t;

  logic clk;
  logic reset;
  multicycle_control_unit_if bus();

  multicycle_control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  outs_t exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  always @(negedge clk) begin
    outs_t e, a;
    string nm;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      a.st = bus.state;           a.pc_en = bus.PCEnable;
      a.iord = bus.IorD;          a.mem_read = bus.MemRead;
      a.mem_write = bus.MemWrite; a.ir_write = bus.IRWrite;
      a.mem_to_reg = bus.MemtoReg; a.reg_dst = bus.RegDst;
      a.reg_write = bus.RegWrite; a.ext_op = bus.ExtOp;
      a.src_a = bus.ALUSrcA;      a.src_b = bus.ALUSrcB;
      a.pc_src = bus.PCSource;    a.alu = bus.ALUOperation;
      a.ill = bus.IllegalInstr;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", nm, a, e);
      end
    end
  end

  // ---------------- expected-vector helpers ----------------
  function automatic outs_t x_reset();
    outs_t e = '0;
    e.st = FETCH; e.src_b = 2'b01; e.alu = 4'b0011;
    return e;
  endfunction

  function automatic outs_t x_fetch(input logic ready);
    outs_t e = '0;
    e.st = FETCH; e.mem_read = 1'b1; e.src_b = 2'b01; e.alu = 4'b0011;
    e.ir_write = ready; e.pc_en = ready;
    return e;
  endfunction

  function automatic outs_t x_decode(input logic ill);
    outs_t e = '0;
    e.st = DECODE; e.src_b = 2'b11; e.alu = 4'b0011; e.ill = ill;
    return e;
  endfunction

  function automatic outs_t x_mem_addr();
    outs_t e = '0;
    e.st = MEM_ADDR; e.src_a = 1'b1; e.src_b = 2'b10; e.alu = 4'b0011;
    return e;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input logic mr, input outs_t e, input string nm);
    bus.Opcode = op; bus.Funct = fn; bus.Zero = z; bus.MemReady = mr;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  logic [5:0] r_fn  [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27};
  logic [3:0] r_alu [5] = '{4'b0011, 4'b0100, 4'b0000, 4'b0001, 4'b0010};

  initial begin
    outs_t e;
    reset = 1'b1;
    bus.Opcode = '0; bus.Funct = '0; bus.Zero = 1'b0; bus.MemReady = 1'b0;
    @(posedge clk);
    #1;
    // MemReady high during reset must not produce any enable.
    step(6'h00, 6'h00, 1'b0, 1'b1, x_reset(), "reset_state");
    reset = 1'b0;

    // R-type sweep with zero-wait memory
    for (int i = 0; i < 5; i++) begin
      step(6'h00, r_fn[i], 1'b0, 1'b1, x_fetch(1'b1), "r_fetch");
      step(6'h00, r_fn[i], 1'b0, 1'b1, x_decode(1'b0), "r_decode");
      e = '0; e.st = EXEC_R; e.src_a = 1'b1; e.src_b = 2'b00; e.alu = r_alu[i];
      step(6'h00, r_fn[i], 1'b0, 1'b1, e, "r_exec");
      e = '0; e.st = R_WB; e.reg_dst = 1'b1; e.reg_write = 1'b1;
      step(6'h00, r_fn[i], 1'b0, 1'b1, e, "r_wb");
    end

    // lw: one fetch stall, then two MEM_READ stall cycles
    step(6'h23, 6'h00, 1'b0, 1'b0, x_fetch(1'b0), "lw_fetch_stall");
    step(6'h23, 6'h00, 1'b0, 1'b1, x_fetch(1'b1), "lw_fetch");
    step(6'h23, 6'h00, 1'b0, 1'b1, x_decode(1'b0), "lw_decode");
    step(6'h23, 6'h00, 1'b0, 1'b1, x_mem_addr(), "lw_mem_addr");
    e = '0; e.st = MEM_READ; e.iord = 1'b1; e.mem_read = 1'b1;
    step(6'h23, 6'h00, 1'b0, 1'b0, e, "lw_read_stall1");
    step(6'h23, 6'h00, 1'b0, 1'b0, e, "lw_read_stall2");
    step(6'h23, 6'h00, 1'b0, 1'b1, e, "lw_read_done");
    e = '0; e.st = MEM_WB; e.mem_to_reg = 1'b1; e.reg_write = 1'b1;
    step(6'h23, 6'h00, 1'b0, 1'b0, e, "lw_mem_wb");

    // sw completing after one stall
    step(6'h2B, 6'h00, 1'b0, 1'b1, x_fetch(1'b1), "sw_fetch");
    step(6'h2B, 6'h00, 1'b0, 1'b1, x_decode(1'b0), "sw_decode");
    step(6'h2B, 6'h00, 1'b0, 1'b0, x_mem_addr(), "sw_mem_addr");
    e = '0; e.st = MEM_WRITE; e.iord = 1'b1; e.mem_write = 1'b1;
    step(6'h2B, 6'h00, 1'b0, 1'b0, e, "sw_write_stall");
    step(6'h2B, 6'h00, 1'b0, 1'b1, e, "sw_write_done");

    // sw aborted by reset mid MEM_WRITE
    step(6'h2B, 6'h00, 1'b0, 1'b1, x_fetch(1'b1), "swr_fetch");
    step(6'h2B, 6'h00, 1'b0, 1'b1, x_decode(1'b0), "swr_decode");
    step(6'h2B, 6'h00, 1'b0, 1'b0, x_mem_addr(), "swr_mem_addr");
    step(6'h2B, 6'h00, 1'b0, 1'b0, e, "swr_write_stall");
    reset = 1'b1;
    step(6'h2B, 6'h00, 1'b0, 1'b1, x_reset(), "swr_reset_abort");
    reset = 1'b0;
    step(6'h2B, 6'h00, 1'b0, 1'b0, x_fetch(1'b0), "swr_after_reset");

    // beq taken and not taken
    for (int z = 1; z >= 0; z--) begin
      step(6'h04, 6'h00, 1'b0, 1'b1, x_fetch(1'b1), "beq_fetch");
      step(6'h04, 6'h00, 1'b0, 1'b1, x_decode(1'b0), "beq_decode");
      e = '0; e.st = BRANCH; e.src_a = 1'b1; e.src_b = 2'b00; e.alu = 4'b0100;
      e.pc_src = 2'b01; e.pc_en = z[0];
      step(6'h04, 6'h00, z[0], 1'b1, e, z[0] ? "beq_taken" : "beq_not_taken");
    end

    // ori then addi
    step(6'h0D, 6'h00, 1'b0, 1'b1, x_fetch(1'b1), "ori_fetch");
    step(6'h0D, 6'h00, 1'b0, 1'b1, x_decode(1'b0), "ori_decode");
    e = '0; e.st = EXEC_I; e.src_a = 1'b1; e.src_b = 2'b10; e.ext_op = 1'b1; e.alu = 4'b0001;
    step(6'h0D, 6'h00, 1'b0, 1'b1, e, "ori_exec");
    e = '0; e.st = I_WB; e.reg_write = 1'b1; e.ext_op = 1'b1;
    step(6'h0D, 6'h00, 1'b0, 1'b1, e, "ori_wb");
    step(6'h08, 6'h00, 1'b0, 1'b1, x_fetch(1'b1), "addi_fetch");
    step(6'h08, 6'h00, 1'b0, 1'b1, x_decode(1'b0), "addi_decode");
    e = '0; e.st = EXEC_I; e.src_a = 1'b1; e.src_b = 2'b10; e.alu = 4'b0011;
    step(6'h08, 6'h00, 1'b0, 1'b1, e, "addi_exec");
    e = '0; e.st = I_WB; e.reg_write = 1'b1;
    step(6'h08, 6'h00, 1'b0, 1'b1, e, "addi_wb");

    // j
    step(6'h02, 6'h00, 1'b0, 1'b1, x_fetch(1'b1), "j_fetch");
    step(6'h02, 6'h00, 1'b0, 1'b1, x_decode(1'b0), "j_decode");
    e = '0; e.st = JUMP; e.pc_en = 1'b1; e.pc_src = 2'b10;
    step(6'h02, 6'h00, 1'b0, 1'b1, e, "j_jump");

    // illegal opcode, then illegal funct
    step(6'h3F, 6'h00, 1'b0, 1'b1, x_fetch(1'b1), "ill_op_fetch");
    step(6'h3F, 6'h00, 1'b0, 1'b1, x_decode(1'b1), "ill_op_decode");
    step(6'h00, 6'h18, 1'b0, 1'b1, x_fetch(1'b1), "ill_fn_fetch");
    step(6'h00, 6'h18, 1'b0, 1'b1, x_decode(1'b1), "ill_fn_decode");
    step(6'h00, 6'h18, 1'b0, 1'b0, x_fetch(1'b0), "ill_return_fetch");

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
